// File: rtl/turn_sequencer.sv
// turn_sequencer: turn counter and active-player arbiter for 2..2^PID_W-1 players.
// Optional macro TURN_LIMIT_EN adds a terminal DONE state after MAX_TURNS turns.

module turn_sequencer #(
   parameter int NUM_PLAYERS    = 2,
   parameter int PID_W          = 2,
   parameter int TURN_W         = 3,
   parameter int TIMEOUT_CYCLES = 600_000_000,
   parameter int MAX_TURNS      = 7
) (
   input  logic              clk60MHz,
   input  logic              rst_n,
   input  logic              throw_flag,
   input  logic              in_throw_flag,
   input  logic [PID_W-1:0]  current_player,
   output logic [TURN_W-1:0] turn,
   output logic [PID_W-1:0]  active_player,
   output logic              turn_pulse,
   output logic              timeout_pulse,
   output logic              game_over
);

   localparam int                CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [PID_W-1:0]  LAST_PID = PID_W'(NUM_PLAYERS);

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_FLIGHT  = 3'd1,
      S_COMMIT  = 3'd2,
      S_FORFEIT = 3'd3
`ifdef TURN_LIMIT_EN
      , S_DONE  = 3'd4
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [TURN_W-1:0] turn_q, turn_d;
   logic [PID_W-1:0]  player_q, player_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              turn_pulse_q, turn_pulse_d;
   logic              timeout_pulse_q, timeout_pulse_d;

   logic              busy, valid_throw, expired;
   logic [PID_W-1:0]  next_pid;

   assign busy        = throw_flag | in_throw_flag;
   assign valid_throw = busy && (current_player == player_q);
   assign expired     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
   assign next_pid    = (player_q < LAST_PID) ? player_q + PID_W'(1) : PID_W'(1);

`ifdef TURN_LIMIT_EN
   localparam logic [TURN_W:0] LIMIT_TURN = (TURN_W+1)'(MAX_TURNS + 1);
   logic limit_hit;
   logic game_over_q, game_over_d;
   // Compared one bit wider so a limit at the top of the counter range still triggers.
   assign limit_hit = ({1'b0, turn_q} + (TURN_W+1)'(1)) == LIMIT_TURN;
`endif

   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_WAIT;
         turn_q          <= TURN_W'(1);
         player_q        <= PID_W'(1);
         cnt_q           <= '0;
         turn_pulse_q    <= 1'b0;
         timeout_pulse_q <= 1'b0;
`ifdef TURN_LIMIT_EN
         game_over_q     <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         turn_q          <= turn_d;
         player_q        <= player_d;
         cnt_q           <= cnt_d;
         turn_pulse_q    <= turn_pulse_d;
         timeout_pulse_q <= timeout_pulse_d;
`ifdef TURN_LIMIT_EN
         game_over_q     <= game_over_d;
`endif
      end
   end

   // A valid throw takes priority over a timeout expiring in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT: begin
            if (valid_throw)  state_d = S_FLIGHT;
            else if (expired) state_d = S_FORFEIT;
         end
         S_FLIGHT:  if (!busy) state_d = S_COMMIT;
         S_COMMIT, S_FORFEIT: begin
`ifdef TURN_LIMIT_EN
            state_d = limit_hit ? S_DONE : S_WAIT;
`else
            state_d = S_WAIT;
`endif
         end
`ifdef TURN_LIMIT_EN
         S_DONE:    state_d = S_DONE;
`endif
         default:   state_d = S_WAIT;
      endcase
   end

   always_comb begin
      turn_d          = turn_q;
      player_d        = player_q;
      cnt_d           = '0;
      turn_pulse_d    = (state_d == S_COMMIT);
      timeout_pulse_d = (state_d == S_FORFEIT);
      if ((TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && (state_d == S_WAIT))
         cnt_d = cnt_q + CNT_W'(1);
      if ((state_q == S_COMMIT) || (state_q == S_FORFEIT)) begin
         turn_d   = turn_q + TURN_W'(1);
         player_d = next_pid;
      end
`ifdef TURN_LIMIT_EN
      game_over_d = (state_d == S_DONE);
`endif
   end

   assign turn          = turn_q;
   assign active_player = player_q;
   assign turn_pulse    = turn_pulse_q;
   assign timeout_pulse = timeout_pulse_q;
`ifdef TURN_LIMIT_EN
   assign game_over     = game_over_q;
`else
   assign game_over     = 1'b0;
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed scenarios then random traffic against a turn-level model.

module tb_turn_sequencer;

   localparam int NP  = 3;
   localparam int TO  = 16;
   localparam int MAXT = 3;
`ifdef TURN_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tf, itf;
   logic [1:0] cp;
   logic [2:0] turn;
   logic [1:0] ap;
   logic       tp, top, go;

   turn_sequencer #(
      .NUM_PLAYERS(NP), .PID_W(2), .TURN_W(3), .TIMEOUT_CYCLES(TO), .MAX_TURNS(MAXT)
   ) dut (
      .clk60MHz(clk), .rst_n(rst_n), .throw_flag(tf), .in_throw_flag(itf),
      .current_player(cp), .turn(turn), .active_player(ap),
      .turn_pulse(tp), .timeout_pulse(top), .game_over(go)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Turn-level model: the game is either idle, in flight, one cycle after a
   // finished/forfeited turn (pulse showing), or over.
   int m_turn, m_player, m_idle;
   bit m_flight, m_tp, m_to, m_done;

   task automatic model_reset();
      m_turn = 1; m_player = 1; m_idle = 0;
      m_flight = 0; m_tp = 0; m_to = 0; m_done = 0;
   endtask

   task automatic model_edge(input bit b, input int who);
      int raw;
      if (m_tp || m_to) begin
         raw      = m_turn + 1;
         m_player = (m_player % NP) + 1;
         m_tp = 0; m_to = 0; m_idle = 0;
         if (LIM && raw == MAXT + 1) begin
            m_done = 1; m_turn = raw;
         end else
            m_turn = raw % 8;
      end else if (m_done) begin
      end else if (m_flight) begin
         if (!b) begin m_flight = 0; m_tp = 1; end
      end else begin
         if (b && who == m_player) begin m_flight = 1; m_idle = 0; end
         else if (m_idle == TO - 1) begin m_to = 1; m_idle = 0; end
         else m_idle++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".turn"}, 32'(turn), 32'(m_turn));
      chk({tag, ".player"}, 32'(ap), 32'(m_player));
      chk({tag, ".turn_pulse"}, 32'(tp), 32'(m_tp));
      chk({tag, ".timeout_pulse"}, 32'(top), 32'(m_to));
      chk({tag, ".game_over"}, 32'(go), 32'(LIM ? m_done : 1'b0));
   endtask

   task automatic cyc(input logic t, input logic it, input logic [1:0] who);
      tf = t; itf = it; cp = who;
      @(posedge clk);
      model_edge(t | it, int'(who));
      #1;
      chk_all("cyc");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst");
      tf = 0; itf = 0; cp = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic throw_by(input logic [1:0] p, input int nbusy);
      for (int i = 0; i < nbusy; i++) cyc(1'b1, 1'b0, p);
      cyc(1'b0, 1'b0, p);
      cyc(1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       sb;
      int         seg;
      logic [1:0] rcp;
      rst_n = 1'b0; tf = 0; itf = 0; cp = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      chk("reset_turn", 32'(turn), 1);
      chk("reset_player", 32'(ap), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Player 1: 3 cycles aiming, 20 in flight, then release.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'd1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 2'd1);
      cyc(1'b0, 1'b0, 2'd1);
      chk("t1_commit_pulse", 32'(tp), 1);
      cyc(1'b0, 1'b0, 2'd0);
      chk("t1_turn", 32'(turn), 2);
      chk("t1_player", 32'(ap), 2);
      chk("t1_pulse_gone", 32'(tp), 0);

      // Wrong player and zero ID are ignored.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'd1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 2'd0);
      cyc(1'b0, 1'b0, 2'd0);
      chk("t3_turn", 32'(turn), 2);
      chk("t3_player", 32'(ap), 2);

      // Three players in rotation.
      do_reset();
      throw_by(2'd1, 2);
      chk("t2_p_after1", 32'(ap), 2);
      throw_by(2'd2, 2);
      chk("t2_p_after2", 32'(ap), 3);
      throw_by(2'd3, 2);
      chk("t2_p_after3", 32'(ap), 1);
      chk("t2_turn", 32'(turn), 4);
      chk("t2_game_over", 32'(go), LIM ? 1 : 0);

`ifdef TURN_LIMIT_EN
      // Game over: nothing moves until reset.
      throw_by(2'd1, 3);
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 2'd0);
      throw_by(2'd1, 2);
      chk("t6_turn_frozen", 32'(turn), 4);
      chk("t6_no_pulse", 32'(tp | top), 0);
      do_reset();
      chk("t6_go_cleared", 32'(go), 0);
`endif

      // Timeout forfeit, then a valid throw exactly in the expiry cycle.
      do_reset();
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 2'd0);
      chk("t4_no_early_to", 32'(top), 0);
      cyc(1'b0, 1'b0, 2'd0);
      chk("t4_to_pulse", 32'(top), 1);
      chk("t4_no_turn_pulse", 32'(tp), 0);
      cyc(1'b0, 1'b0, 2'd0);
      chk("t4_turn", 32'(turn), 2);
      chk("t4_player", 32'(ap), 2);
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 2'd2);
      chk("t4_throw_wins", 32'(top), 0);
      cyc(1'b0, 1'b0, 2'd2);
      chk("t4_commit", 32'(tp), 1);
      cyc(1'b0, 1'b0, 2'd0);
      chk("t4_turn2", 32'(turn), 3);

`ifndef TURN_LIMIT_EN
      // Turn counter wraps 7 -> 0.
      do_reset();
      for (int k = 0; k < 6; k++) throw_by(2'((k % NP) + 1), 1);
      chk("t5_turn7", 32'(turn), 7);
      throw_by(2'd1, 1);
      chk("t5_wrap", 32'(turn), 0);
`endif

      // Reset in the middle of a flight aborts the turn.
      do_reset();
      cyc(1'b1, 1'b0, 2'd1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd1);
      do_reset();
      chk("t5_rst_turn", 32'(turn), 1);
      chk("t5_rst_pulse", 32'(tp), 0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'd0);
      chk("t5_no_commit", 32'(tp), 0);
      chk("t5_turn_kept", 32'(turn), 1);

      // Random traffic.
      seg = 0; sb = 0; rcp = 0;
      for (int i = 0; i < 800; i++) begin
         if (seg == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               sb = 0; seg = $urandom_range(1, 20);
            end else begin
               sb = 1; seg = $urandom_range(1, 8);
               rcp = ($urandom_range(0, 2) != 0) ? 2'(m_player) : 2'($urandom_range(0, 3));
            end
         end
         if ($urandom_range(0, 9) == 0) rcp = 2'($urandom_range(0, 3));
         if (sb) begin
            tf  = 1'($urandom_range(0, 1));
            itf = tf ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            tf = 0; itf = 0;
         end
         cyc(tf, itf, rcp);
         seg--;
         if ($urandom_range(0, 249) == 0 || (m_done && $urandom_range(0, 29) == 0))
            do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
